// File: rtl/irq_controller.sv
// Interrupt controller: synchronises NUM_IRQ raw lines, latches edge/level pending state,
// masks by enable and arbitrates lowest-index-first behind a claim/complete register.
module irq_controller #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [NUM_IRQ-1:0] I_irq,
    input  logic               I_wen,
    input  logic               I_ren,
    input  logic [1:0]         I_addr,
    input  logic [31:0]        I_wdata,
    output logic [31:0]        O_rdata,
    output logic               O_extinterrupt
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sdly_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] inservice_q, inservice_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ext_q, ext_d;

    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] cand_s;
    logic [NUM_IRQ-1:0] claim_mask_s;
    logic [NUM_IRQ-1:0] complete_mask_s;
    logic [31:0]        winner_id_s;
    logic               claim_s;

    assign O_rdata        = rdata_q;
    assign O_extinterrupt = ext_q;

    // Next-state logic: arbitration, claim/complete, register writes and read mux
    always_comb begin
        sync_s  = sync_q[SYNC_STAGES-1];
        rise_s  = sync_s & ~sdly_q;
        cand_s  = pending_q & enable_q & ~inservice_q;
        claim_s = I_ren && (I_addr == 2'd3) && (cand_s != '0);

        winner_id_s = 32'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            winner_id_s = cand_s[i] ? 32'(i + 1) : winner_id_s;
        end
        // Isolating the lowest set bit gives the winner as a one-hot mask
        claim_mask_s = claim_s ? (cand_s & (~cand_s + NUM_IRQ'(1))) : '0;

        complete_mask_s = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            complete_mask_s[i] = I_wen && (I_addr == 2'd3) && (I_wdata == 32'(i + 1));
        end
        complete_mask_s = complete_mask_s & inservice_q;

        pending_d   = (mode_q & ((pending_q & ~claim_mask_s) | rise_s)) | (~mode_q & sync_s);
        inservice_d = (inservice_q | claim_mask_s) & ~complete_mask_s;
        ext_d       = (cand_s != '0) && (inservice_q == '0);

        if (I_wen && (I_addr == 2'd1)) begin
            enable_d = I_wdata[NUM_IRQ-1:0];
        end else begin
            enable_d = enable_q;
        end
        if (I_wen && (I_addr == 2'd2)) begin
            mode_d = I_wdata[NUM_IRQ-1:0];
        end else begin
            mode_d = mode_q;
        end

        if (I_ren) begin
            case (I_addr)
                2'd0:    rdata_d = 32'(pending_q);
                2'd1:    rdata_d = 32'(enable_q);
                2'd2:    rdata_d = 32'(mode_q);
                2'd3:    rdata_d = winner_id_s;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            sdly_q      <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            inservice_q <= '0;
            rdata_q     <= 32'd0;
            ext_q       <= 1'b0;
        end else begin
            sync_q[0] <= I_irq;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            sdly_q      <= sync_s;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            inservice_q <= inservice_d;
            rdata_q     <= rdata_d;
            ext_q       <= ext_d;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random traffic, all
// compared cycle by cycle against a behavioural model of the controller's rules.
module tb_irq_controller;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam logic [15:0] MASK = 16'((1 << N) - 1);

    logic          I_clk;
    logic          I_rst;
    logic [N-1:0]  I_irq;
    logic          I_wen;
    logic          I_ren;
    logic [1:0]    I_addr;
    logic [31:0]   I_wdata;
    logic [31:0]   O_rdata;
    logic          O_extinterrupt;

    int checks;
    int errors;

    logic [15:0] irq_v;
    logic [15:0] m_pend, m_en, m_md, m_isv;
    logic [31:0] m_rdata;
    logic        m_ext;
    logic [15:0] hist [SS+1];

    irq_controller #(.NUM_IRQ(N), .SYNC_STAGES(SS)) dut (
        .I_clk          (I_clk),
        .I_rst          (I_rst),
        .I_irq          (I_irq),
        .I_wen          (I_wen),
        .I_ren          (I_ren),
        .I_addr         (I_addr),
        .I_wdata        (I_wdata),
        .O_rdata        (O_rdata),
        .O_extinterrupt (O_extinterrupt)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: one call per clock edge, using the inputs present at that edge
    task automatic model_step(input logic rst, input logic [15:0] irq, input logic wen,
                              input logic ren, input logic [1:0] addr, input logic [31:0] wdata);
        logic [15:0] s, sd, np, nisv;
        int win;
        if (rst) begin
            m_pend = 16'h0; m_en = 16'h0; m_md = 16'h0; m_isv = 16'h0;
            m_rdata = 32'h0; m_ext = 1'b0;
            for (int k = 0; k <= SS; k++) hist[k] = 16'h0;
        end else begin
            s   = hist[SS-1];
            sd  = hist[SS];
            win = -1;
            for (int i = N - 1; i >= 0; i--)
                if (m_pend[i] && m_en[i] && !m_isv[i]) win = i;
            if (ren) begin
                case (addr)
                    2'd0:    m_rdata = {16'h0, m_pend};
                    2'd1:    m_rdata = {16'h0, m_en};
                    2'd2:    m_rdata = {16'h0, m_md};
                    default: m_rdata = (win < 0) ? 32'd0 : 32'(win + 1);
                endcase
            end
            np   = m_pend;
            nisv = m_isv;
            for (int i = 0; i < N; i++) begin
                if (m_md[i]) begin
                    if (ren && addr == 2'd3 && win == i) np[i] = 1'b0;
                    if (s[i] && !sd[i]) np[i] = 1'b1;
                end else begin
                    np[i] = s[i];
                end
            end
            if (ren && addr == 2'd3 && win >= 0) nisv[win] = 1'b1;
            if (wen && addr == 2'd3 && wdata >= 1 && wdata <= N && m_isv[wdata-1])
                nisv[wdata-1] = 1'b0;
            m_ext = (win >= 0) && (m_isv == 16'h0);
            if (wen && addr == 2'd1) m_en = wdata[15:0] & MASK;
            if (wen && addr == 2'd2) m_md = wdata[15:0] & MASK;
            m_pend = np;
            m_isv  = nisv;
            for (int k = SS; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = irq & MASK;
        end
    endtask

    task automatic cyc(input logic rst, input logic wen, input logic ren,
                       input logic [1:0] addr, input logic [31:0] wdata);
        I_rst   = rst;
        I_irq   = irq_v[N-1:0];
        I_wen   = wen;
        I_ren   = ren;
        I_addr  = addr;
        I_wdata = wdata;
        @(posedge I_clk);
        model_step(rst, irq_v, wen, ren, addr, wdata);
        #1;
        chk("ext", {31'd0, O_extinterrupt}, {31'd0, m_ext});
        chk("rdata", O_rdata, m_rdata);
        @(negedge I_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        irq_v = 16'h0;
        I_rst = 1'b1; I_irq = '0; I_wen = 1'b0; I_ren = 1'b0; I_addr = 2'd0; I_wdata = 32'd0;
        @(negedge I_clk);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 2'd1, 32'hFF);
        chk("rst_ext", {31'd0, O_extinterrupt}, 32'd0);
        chk("rst_rdata", O_rdata, 32'd0);

        // 1: edge source 0, latency and claim
        wr(2'd1, 32'h01); wr(2'd2, 32'h01);
        irq_v = 16'h01; idle(1);
        irq_v = 16'h00; idle(2);
        chk("t1_early", {31'd0, O_extinterrupt}, 32'd0);
        idle(1);
        chk("t1_lat", {31'd0, O_extinterrupt}, 32'd1);
        rd(2'd3);
        chk("t1_claim", O_rdata, 32'd1);
        idle(1);
        chk("t1_drop", {31'd0, O_extinterrupt}, 32'd0);
        rd(2'd0);
        chk("t1_pend", O_rdata, 32'd0);
        wr(2'd3, 32'd1);

        // 2: simultaneous edges on 5 and 2
        wr(2'd1, 32'h24); wr(2'd2, 32'h24);
        irq_v = 16'h24; idle(4);
        rd(2'd3);
        chk("t2_claim3", O_rdata, 32'd3);
        idle(2);
        chk("t2_noreq", {31'd0, O_extinterrupt}, 32'd0);
        wr(2'd3, 32'd3); idle(1);
        chk("t2_reassert", {31'd0, O_extinterrupt}, 32'd1);
        rd(2'd3);
        chk("t2_claim6", O_rdata, 32'd6);
        wr(2'd3, 32'd6);
        irq_v = 16'h00;

        // 3: level source 4
        wr(2'd1, 32'h10); wr(2'd2, 32'h00);
        irq_v = 16'h10; idle(4);
        chk("t3_req", {31'd0, O_extinterrupt}, 32'd1);
        rd(2'd3);
        chk("t3_claim", O_rdata, 32'd5);
        wr(2'd3, 32'd5); idle(1);
        chk("t3_again", {31'd0, O_extinterrupt}, 32'd1);
        rd(2'd3);
        irq_v = 16'h00; idle(4);
        wr(2'd3, 32'd5); idle(3);
        chk("t3_quiet", {31'd0, O_extinterrupt}, 32'd0);

        // 4: empty claim and ignored completes
        rd(2'd3);
        chk("t4_empty", O_rdata, 32'd0);
        irq_v = 16'h10; idle(4);
        rd(2'd3);
        wr(2'd3, 32'd0); wr(2'd3, 32'd9); wr(2'd3, 32'd2); idle(2);
        chk("t4_held", {31'd0, O_extinterrupt}, 32'd0);
        wr(2'd3, 32'd5); idle(1);
        chk("t4_done", {31'd0, O_extinterrupt}, 32'd1);
        irq_v = 16'h00; idle(4);
        rd(2'd3);
        chk("t4_empty2", O_rdata, 32'd0);

        // 5: edge coinciding with claim of the same source
        wr(2'd1, 32'h02); wr(2'd2, 32'h02);
        irq_v = 16'h02; idle(1);
        irq_v = 16'h00; idle(4);
        irq_v = 16'h02; idle(1);
        irq_v = 16'h00; idle(1);
        rd(2'd3);
        chk("t5_claim", O_rdata, 32'd2);
        rd(2'd0);
        chk("t5_pend", O_rdata, 32'd2);
        wr(2'd3, 32'd2); idle(1);
        chk("t5_req", {31'd0, O_extinterrupt}, 32'd1);
        rd(2'd3);
        chk("t5_claim2", O_rdata, 32'd2);
        wr(2'd3, 32'd2);

        // 6: reset with a source in service and pending
        wr(2'd1, 32'h08); wr(2'd2, 32'h08);
        irq_v = 16'h08; idle(1);
        irq_v = 16'h00; idle(4);
        rd(2'd3);
        irq_v = 16'h08; idle(1);
        irq_v = 16'h00; idle(3);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("t6_ext", {31'd0, O_extinterrupt}, 32'd0);
        chk("t6_rdata", O_rdata, 32'd0);
        rd(2'd1);
        chk("t6_enable", O_rdata, 32'd0);
        rd(2'd0);
        chk("t6_pend", O_rdata, 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int op;
            if ($urandom_range(0, 3) == 0) irq_v = 16'($urandom) & MASK;
            op = $urandom_range(0, 11);
            if ($urandom_range(0, 499) == 0) begin
                cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
            end else begin
                case (op)
                    0, 1, 2: rd(2'($urandom_range(0, 3)));
                    3, 4:    wr(2'd3, 32'($urandom_range(0, 10)));
                    5:       wr(2'd1, $urandom);
                    6:       wr(2'd2, $urandom);
                    7:       wr(2'd0, $urandom);
                    8:       cyc(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)),
                                 32'($urandom_range(0, 10)));
                    default: idle(1);
                endcase
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
